mem_access_unit: RTL and testbench

Sequential data-memory port controller for the EX/M stage, directly downstream of the store-data aligner. Per load/store from the pipeline, it checks alignment and registers the aligned store data and byte mask. It then issues one ready/valid request to data memory, waits for the load response, and returns sign/zero-extended load data to writeback. It holds `busy` high so the core can stall while an access is in flight.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/load_extract.sv | 38 +++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 encodings,
// controller states and the alignment check.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2
   } mau_state_t;

   // funct3[1:0] gives the access size; the undefined encodings 011/110/111
   // fall through to the word case.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction: selects the byte/half lane from the raw
// memory word and sign- or zero-extends it to 32 bits.
module load_extract
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'h000000, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'h0000, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// EX/M data-memory port controller: alignment check, one ready/valid request
// per access, and extended load return to writeback.
//
// state       | meaning
// ST_IDLE     | no access in flight; accepts a new pipeline request
// ST_REQ      | request presented to memory, outputs held until ready
// ST_WAIT_RSP | load accepted by memory, waiting for read data
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_load,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_wmask,
   output logic              busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_data,
   output logic              st_done,
   output logic              misalign
);

   mau_state_t        state_q, state_d;
   logic              busy_q, busy_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] ld_data_q, ld_data_d;
   logic              ld_valid_q, ld_valid_d;
   logic              st_done_q, st_done_d;
   logic              misalign_q, misalign_d;
   logic [31:0]       ext_data;

   load_extract u_load_extract (
      .rdata   (mem_rsp_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .result  (ext_data)
   );

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      addr_lo_d  = addr_lo_q;
      funct3_d   = funct3_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      ld_data_d  = ld_data_q;
      ld_valid_d = 1'b0;
      st_done_d  = 1'b0;
      misalign_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_funct3, req_addr[1:0])) begin
                  misalign_d = 1'b1;
               end else begin
                  we_d      = ~req_load;
                  addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
                  addr_lo_d = req_addr[1:0];
                  funct3_d  = req_funct3;
                  wdata_d   = req_wdata;
                  wstrb_d   = req_load ? 4'b0000 : req_wmask;
                  state_d   = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               if (we_q) begin
                  st_done_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d   = ST_WAIT_RSP;
               end
            end
         end
         ST_WAIT_RSP: begin
            if (mem_rsp_valid) begin
               ld_data_d  = ext_data;
               ld_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // busy tracks the next state so it drops in the same cycle the pulse appears
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         addr_lo_q  <= 2'b00;
         funct3_q   <= 3'b000;
         wdata_q    <= '0;
         wstrb_q    <= 4'b0000;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         st_done_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         addr_lo_q  <= addr_lo_d;
         funct3_q   <= funct3_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         ld_data_q  <= ld_data_d;
         ld_valid_q <= ld_valid_d;
         st_done_q  <= st_done_d;
         misalign_q <= misalign_d;
      end
   end

   assign busy          = busy_q;
   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign ld_valid      = ld_valid_q;
   assign ld_data       = ld_data_q;
   assign st_done       = st_done_q;
   assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; inputs change and outputs
// are sampled on the falling edge.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_load;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        busy;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        st_done;
   logic        misalign;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_load      (req_load),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wmask     (req_wmask),
      .busy          (busy),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .ld_valid      (ld_valid),
      .ld_data       (ld_data),
      .st_done       (st_done),
      .misalign      (misalign)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; returns at the following negedge.
   task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm);
      req_valid  = 1'b1;
      req_load   = ld;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_wmask  = wm;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   // Full load with ready high and the response one cycle after the handshake.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
      mem_req_ready = 1'b1;
      issue(1'b1, f3, addr, 32'h0, 4'hF);
      check({tag, " req_valid"}, {31'h0, mem_req_valid}, 32'h1);
      check({tag, " wstrb"}, {28'h0, mem_wstrb}, 32'h0);
      check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({tag, " busy wait"}, {31'h0, busy}, 32'h1);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check({tag, " ld_valid"}, {31'h0, ld_valid}, 32'h1);
      check({tag, " ld_data"}, ld_data, exp);
      check({tag, " busy done"}, {31'h0, busy}, 32'h0);
      @(negedge clk);
      check({tag, " ld_valid pulse"}, {31'h0, ld_valid}, 32'h0);
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_load      = 1'b0;
      req_funct3    = 3'b000;
      req_addr      = 32'h0;
      req_wdata     = 32'h0;
      req_wmask     = 4'h0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'h0;

      #12;
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
      check("rst mem_we", {31'h0, mem_we}, 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst ld_data", ld_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // SW with memory stalling for three cycles
      issue(1'b0, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         check("sw req_valid", {31'h0, mem_req_valid}, 32'h1);
         check("sw addr", mem_addr, 32'h0000_1004);
         check("sw we", {31'h0, mem_we}, 32'h1);
         check("sw wdata", mem_wdata, 32'hDEAD_BEEF);
         check("sw wstrb", {28'h0, mem_wstrb}, 32'hF);
         check("sw busy", {31'h0, busy}, 32'h1);
         check("sw st_done early", {31'h0, st_done}, 32'h0);
         @(negedge clk);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("sw st_done", {31'h0, st_done}, 32'h1);
      check("sw busy done", {31'h0, busy}, 32'h0);
      check("sw req dropped", {31'h0, mem_req_valid}, 32'h0);
      @(negedge clk);
      check("sw st_done pulse", {31'h0, st_done}, 32'h0);

      do_load("lb",  3'b000, 32'h0000_2003, 32'h80AB_CD12, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_2003, 32'h80AB_CD12, 32'h0000_0080);
      do_load("lb0", 3'b000, 32'h0000_2000, 32'h80AB_CD12, 32'h0000_0012);
      do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
      do_load("lh0", 3'b001, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);
      do_load("lw",  3'b010, 32'h0000_2008, 32'h1234_5678, 32'h1234_5678);
      do_load("f3_111", 3'b111, 32'h0000_200C, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Misaligned LW
      mem_req_ready = 1'b1;
      issue(1'b1, 3'b010, 32'h0000_3001, 32'h0, 4'h0);
      check("mis pulse", {31'h0, misalign}, 32'h1);
      check("mis busy", {31'h0, busy}, 32'h0);
      check("mis no req", {31'h0, mem_req_valid}, 32'h0);
      @(negedge clk);
      check("mis pulse end", {31'h0, misalign}, 32'h0);
      check("mis still no req", {31'h0, mem_req_valid}, 32'h0);
      check("mis busy after", {31'h0, busy}, 32'h0);
      issue(1'b1, 3'b001, 32'h0000_3003, 32'h0, 4'h0);
      check("mis lh pulse", {31'h0, misalign}, 32'h1);
      check("mis lh no req", {31'h0, mem_req_valid}, 32'h0);

      // Reset while waiting for a load response
      issue(1'b1, 3'b010, 32'h0000_4000, 32'h0, 4'h0);
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("rst-mid busy before", {31'h0, busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rst-mid busy", {31'h0, busy}, 32'h0);
      check("rst-mid req", {31'h0, mem_req_valid}, 32'h0);
      check("rst-mid addr", mem_addr, 32'h0);
      check("rst-mid ld_data", ld_data, 32'h0);
      check("rst-mid wdata", mem_wdata, 32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("rst-mid no ld_valid", {31'h0, ld_valid}, 32'h0);
      check("rst-mid ld_data kept", ld_data, 32'h0);
      @(negedge clk);
      check("rst-mid no ld_valid 2", {31'h0, ld_valid}, 32'h0);

      // SB then LW presented in the st_done cycle
      mem_req_ready = 1'b1;
      issue(1'b0, 3'b000, 32'h0000_5001, 32'h0000_AB00, 4'b0010);
      check("b2b sb wstrb", {28'h0, mem_wstrb}, 32'h2);
      check("b2b sb addr", mem_addr, 32'h0000_5000);
      @(negedge clk);
      check("b2b st_done", {31'h0, st_done}, 32'h1);
      issue(1'b1, 3'b010, 32'h0000_6000, 32'h0, 4'hF);
      check("b2b lw req", {31'h0, mem_req_valid}, 32'h1);
      check("b2b lw wstrb", {28'h0, mem_wstrb}, 32'h0);
      check("b2b lw we", {31'h0, mem_we}, 32'h0);
      check("b2b lw addr", mem_addr, 32'h0000_6000);
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("b2b lw ld_valid", {31'h0, ld_valid}, 32'h1);
      check("b2b lw ld_data", ld_data, 32'h0BAD_F00D);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
